sprite_actor: RTL and testbench

Parametrised motion and animation controller for one on-screen game actor, successor to the single-purpose menu character block. Runs horizontal and vertical movement state machines once per video frame, with configurable jump arc, terminal fall velocity, wrap or clamp screen edges and an N-frame walk cycle. Outputs sprite position, facing, ROM frame base address and a line-start pulse for the downstream `sprite` renderer and palette path.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_anim_seq.sv | 56 +++++
 rtl/sprite_actor.sv | 177 +++++++++++++++++
 tb/tb_sprite_actor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared state encodings and control bit positions for the sprite actor.
package sprite_pkg;

  typedef enum logic [1:0] {
    Y_IDLE = 2'd0,
    Y_JUMP = 2'd1,
    Y_FALL = 2'd2
  } movey_t;

  typedef enum logic [1:0] {
    X_IDLE  = 2'd0,
    X_LEFT  = 2'd1,
    X_RIGHT = 2'd2
  } movex_t;

  localparam int CTRL_LEFT  = 0;
  localparam int CTRL_RIGHT = 1;
  localparam int CTRL_JUMP  = 4;

endpackage

// File: rtl/sprite_anim_seq.sv
// rtl/sprite_anim_seq.sv - walk/jump animation step sequencer and frame ROM base address.
module sprite_anim_seq #(
  parameter int FRAMES           = 3,
  parameter int ANIM_PERIOD      = 16,
  parameter int JUMP_ANIM_PERIOD = 2,
  parameter int SPR_W            = 19,
  parameter int SPR_H            = 27,
  parameter int ADDRW            = 11
) (
  input  logic             i_clk_pix,
  input  logic             i_rst_n,
  input  logic             i_frame,
  input  logic             i_moving,
  input  logic             i_airborne,
  output logic [ADDRW-1:0] o_base_addr
);

  localparam int STEPS = 2 * (FRAMES - 1);
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PMAX  = (ANIM_PERIOD > JUMP_ANIM_PERIOD) ? ANIM_PERIOD : JUMP_ANIM_PERIOD;
  localparam int CW    = $clog2(PMAX + 1);

  logic [CW-1:0]    cnt_q, cnt_d, period_last;
  logic [SW-1:0]    step_q, step_d;
  logic [ADDRW-1:0] addr_d;

  always_comb begin
    cnt_d       = cnt_q;
    step_d      = step_q;
    period_last = i_airborne ? CW'(JUMP_ANIM_PERIOD - 1) : CW'(ANIM_PERIOD - 1);
    if (!i_moving) begin
      cnt_d  = '0;
      step_d = '0;
    end else if (cnt_q >= period_last) begin
      // >= catches a count left over from the longer grounded period on take-off
      cnt_d  = '0;
      step_d = (step_q == SW'(STEPS - 1)) ? '0 : step_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    addr_d = step_d[0] ? ADDRW'((int'(step_d >> 1) + 1) * SPR_W * SPR_H) : '0;
  end

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      cnt_q       <= '0;
      step_q      <= '0;
      o_base_addr <= '0;
    end else if (i_frame) begin
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      o_base_addr <= addr_d;
    end
  end

endmodule

// File: rtl/sprite_actor.sv
// rtl/sprite_actor.sv - per-frame X/Y motion FSMs, edge handling and landing detect for one actor.
module sprite_actor
  import sprite_pkg::*;
#(
  parameter int CORDW            = 16,
  parameter int H_RES            = 800,
  parameter int V_RES            = 600,
  parameter int SPR_W            = 19,
  parameter int SPR_H            = 27,
  parameter int SCALE_X          = 2,
  parameter int SCALE_Y          = 2,
  parameter int FRAMES           = 3,
  parameter int ANIM_PERIOD      = 16,
  parameter int JUMP_ANIM_PERIOD = 2,
  parameter int JUMP_FRAMES      = 20,
  parameter int MAX_FALL         = 12,
  parameter int EDGE_MODE        = 0,
  parameter int ADDRW            = $clog2(SPR_W * SPR_H * FRAMES)
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst_n,
  input  logic [5:0]              i_ctrl,
  input  logic                    i_frame,
  input  logic                    i_line,
  input  logic signed [CORDW-1:0] i_sy,
  input  logic [7:0]              i_speed,
  input  logic [CORDW-1:0]        i_floor,
  input  logic signed [CORDW-1:0] i_spawn_x,
  input  logic signed [CORDW-1:0] i_spawn_y,
  output logic signed [CORDW-1:0] o_sprx,
  output logic signed [CORDW-1:0] o_spry,
  output logic                    o_face,
  output logic [ADDRW-1:0]        o_base_addr,
  output logic                    o_spr_start,
  output logic [1:0]              o_state_y,
  output logic                    o_landed
);

  localparam int JW = $clog2(JUMP_FRAMES + 1);
  localparam int FW = $clog2(MAX_FALL + 1);
  localparam logic signed [CORDW-1:0] W_S    = CORDW'(SPR_W * SCALE_X);
  localparam logic signed [CORDW-1:0] H_S    = CORDW'(SPR_H * SCALE_Y);
  localparam logic signed [CORDW-1:0] HRES_S = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] VRES_S = CORDW'(V_RES);
  localparam logic signed [CORDW-1:0] XMAX_S = CORDW'(H_RES - SPR_W * SCALE_X);
  localparam logic signed [CORDW-1:0] JF_S   = CORDW'(JUMP_FRAMES);

  movex_t                  x_q, x_d;
  movey_t                  y_q, y_d;
  logic signed [CORDW-1:0] sprx_d, spry_d, x_new, fall_sum, floor_y, speed_s, jump_step, v_s;
  logic                    face_d, landed_d;
  logic [JW-1:0]           cnt_jump_q, cnt_jump_d;
  logic [FW-1:0]           cnt_fall_q, cnt_fall_d, v;
  logic                    moving, airborne;
  logic                    ctrl_unused;

  assign ctrl_unused = ^{i_ctrl[5], i_ctrl[3:2]};
  assign floor_y     = VRES_S - $signed(i_floor) - H_S;
  assign speed_s     = $signed({{(CORDW-8){1'b0}}, i_speed});
  assign jump_step   = JF_S - $signed({{(CORDW-JW){1'b0}}, cnt_jump_q});
  assign v           = (cnt_fall_q < FW'(MAX_FALL)) ? cnt_fall_q : FW'(MAX_FALL);
  assign v_s         = $signed({{(CORDW-FW){1'b0}}, v});
  assign fall_sum    = o_spry + v_s;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    sprx_d     = o_sprx;
    spry_d     = o_spry;
    face_d     = o_face;
    cnt_jump_d = cnt_jump_q;
    cnt_fall_d = cnt_fall_q;
    landed_d   = 1'b0;
    x_new      = o_sprx;
    if (i_frame) begin
      if (i_ctrl[CTRL_RIGHT])     x_d = X_RIGHT;
      else if (i_ctrl[CTRL_LEFT]) x_d = X_LEFT;
      else                        x_d = X_IDLE;

      case (x_d)
        X_RIGHT: begin x_new = o_sprx + speed_s; face_d = 1'b0; end
        X_LEFT:  begin x_new = o_sprx - speed_s; face_d = 1'b1; end
        default: x_new = o_sprx;
      endcase

      // Edge handling only on movement so an idle actor keeps an off-range spawn
      if (x_d != X_IDLE) begin
        sprx_d = x_new;
        if (EDGE_MODE == 0) begin
          if (x_new > HRES_S)    sprx_d = -W_S;
          else if (x_new < -W_S) sprx_d = HRES_S;
        end else begin
          if (x_new[CORDW-1])    sprx_d = '0;
          else if (x_new > XMAX_S) sprx_d = XMAX_S;
        end
      end

      case (y_q)
        Y_IDLE: begin
          if (i_ctrl[CTRL_JUMP]) begin
            y_d        = Y_JUMP;
            cnt_jump_d = '0;
          end else if (o_spry < floor_y) begin
            y_d        = Y_FALL;
            cnt_fall_d = '0;
          end else begin
            spry_d = floor_y;
          end
        end
        Y_JUMP: begin
          spry_d = o_spry - jump_step;
          if (cnt_jump_q == JW'(JUMP_FRAMES - 1)) begin
            y_d        = Y_FALL;
            cnt_fall_d = '0;
          end else begin
            cnt_jump_d = cnt_jump_q + 1'b1;
          end
        end
        Y_FALL: begin
          if (fall_sum >= floor_y) begin
            spry_d   = floor_y;
            y_d      = Y_IDLE;
            landed_d = 1'b1;
          end else begin
            spry_d = fall_sum;
            if (cnt_fall_q < FW'(MAX_FALL)) cnt_fall_d = cnt_fall_q + 1'b1;
          end
        end
        default: y_d = Y_FALL;
      endcase
    end
  end

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      x_q        <= X_IDLE;
      y_q        <= Y_FALL;
      o_sprx     <= i_spawn_x;
      o_spry     <= i_spawn_y;
      o_face     <= 1'b0;
      cnt_jump_q <= '0;
      cnt_fall_q <= '0;
      o_landed   <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      o_sprx     <= sprx_d;
      o_spry     <= spry_d;
      o_face     <= face_d;
      cnt_jump_q <= cnt_jump_d;
      cnt_fall_q <= cnt_fall_d;
      o_landed   <= landed_d;
    end
  end

  assign moving      = (x_d != X_IDLE) || (y_d != Y_IDLE);
  assign airborne    = (y_d != Y_IDLE);
  assign o_state_y   = y_q;
  assign o_spr_start = i_line && (i_sy == o_spry);

  sprite_anim_seq #(
    .FRAMES          (FRAMES),
    .ANIM_PERIOD     (ANIM_PERIOD),
    .JUMP_ANIM_PERIOD(JUMP_ANIM_PERIOD),
    .SPR_W           (SPR_W),
    .SPR_H           (SPR_H),
    .ADDRW           (ADDRW)
  ) u_anim (
    .i_clk_pix  (i_clk_pix),
    .i_rst_n    (i_rst_n),
    .i_frame    (i_frame),
    .i_moving   (moving),
    .i_airborne (airborne),
    .o_base_addr(o_base_addr)
  );

endmodule

// File: tb/tb_sprite_actor.sv
// tb/tb_sprite_actor.sv - directed self-checking bench for sprite_actor (wrap and clamp instances).
module tb_sprite_actor;

  logic               clk = 1'b0;
  logic               rst_n, c_rst_n;
  logic [5:0]         i_ctrl;
  logic               i_frame, i_line;
  logic signed [15:0] i_sy, spawn_x, spawn_y, c_spawn_x;
  logic [7:0]         i_speed;
  logic [15:0]        i_floor;

  logic signed [15:0] sprx, spry, c_sprx, c_spry;
  logic               face, spr_start, landed, c_face, c_spr_start, c_landed;
  logic [10:0]        base_addr, c_base_addr;
  logic [1:0]         state_y, c_state_y;

  int tests = 0;
  int fails = 0;
  int land_frame;
  bit landed_seen;

  always #5 clk = ~clk;

  sprite_actor #(.EDGE_MODE(0)) dut (
    .i_clk_pix(clk), .i_rst_n(rst_n), .i_ctrl(i_ctrl), .i_frame(i_frame), .i_line(i_line),
    .i_sy(i_sy), .i_speed(i_speed), .i_floor(i_floor), .i_spawn_x(spawn_x), .i_spawn_y(spawn_y),
    .o_sprx(sprx), .o_spry(spry), .o_face(face), .o_base_addr(base_addr),
    .o_spr_start(spr_start), .o_state_y(state_y), .o_landed(landed)
  );

  sprite_actor #(.EDGE_MODE(1)) u_clamp (
    .i_clk_pix(clk), .i_rst_n(c_rst_n), .i_ctrl(i_ctrl), .i_frame(i_frame), .i_line(i_line),
    .i_sy(i_sy), .i_speed(i_speed), .i_floor(i_floor), .i_spawn_x(c_spawn_x), .i_spawn_y(spawn_y),
    .o_sprx(c_sprx), .o_spry(c_spry), .o_face(c_face), .o_base_addr(c_base_addr),
    .o_spr_start(c_spr_start), .o_state_y(c_state_y), .o_landed(c_landed)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input logic [5:0] ctrl);
    @(negedge clk);
    i_ctrl  = ctrl;
    i_frame = 1'b1;
    @(negedge clk);
    i_frame = 1'b0;
  endtask

  // Frame strobe held high during reset to show reset wins
  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    i_frame = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    i_frame = 1'b0;
  endtask

  task automatic do_creset();
    @(negedge clk);
    c_rst_n = 1'b0;
    @(negedge clk);
    c_rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; c_rst_n = 1'b0;
    i_ctrl = '0; i_frame = 1'b0; i_line = 1'b0; i_sy = '0;
    i_speed = 8'd4; i_floor = 16'd100;
    spawn_x = 16'sd100; spawn_y = -16'sd200; c_spawn_x = '0;
    do_reset();
    c_rst_n = 1'b1;

    chk("rst_sprx", sprx, 100);
    chk("rst_spry", spry, -200);
    chk("rst_state_y", state_y, 2);
    chk("rst_face", face, 0);
    chk("rst_base", base_addr, 0);
    chk("rst_landed", landed, 0);

    do_frame(6'd0); chk("fall_f1", spry, -200);
    do_frame(6'd0); chk("fall_f2", spry, -199);
    do_frame(6'd0); chk("fall_f3", spry, -197);
    do_frame(6'd0); chk("fall_f4", spry, -194);
    land_frame = -1;
    landed_seen = 1'b0;
    for (int f = 5; f <= 200 && !landed_seen; f++) begin
      do_frame(6'd0);
      if (landed) begin
        land_frame  = f;
        landed_seen = 1'b1;
      end
    end
    chk("land_frame", land_frame, 61);
    chk("land_spry", spry, 446);
    chk("land_state", state_y, 0);
    @(negedge clk);
    chk("landed_one_cycle", landed, 0);

    i_line = 1'b1; i_sy = 16'sd446;
    #1 chk("spr_start_hit", spr_start, 1);
    i_sy = 16'sd445;
    #1 chk("spr_start_miss", spr_start, 0);
    i_line = 1'b0; i_sy = 16'sd446;
    #1 chk("spr_start_noline", spr_start, 0);

    do_frame(6'h10);
    chk("jump_state", state_y, 1);
    chk("jump_start_spry", spry, 446);
    do_frame(6'd0);
    chk("jump_f1", spry, 426);
    for (int i = 2; i <= 20; i++) do_frame(6'd0);
    chk("jump_apex", spry, 236);
    chk("jump_to_fall", state_y, 2);
    do_frame(6'h10);
    chk("no_double_jump", state_y, 2);
    landed_seen = 1'b0;
    for (int f = 0; f < 100 && !landed_seen; f++) begin
      do_frame(6'd0);
      if (landed) landed_seen = 1'b1;
    end
    chk("jump_landed", int'(landed_seen), 1);
    chk("jump_return_spry", spry, 446);

    for (int f = 1; f <= 64; f++) begin
      do_frame(6'h02);
      if (f == 15) chk("anim_f15", base_addr, 0);
      if (f == 16) chk("anim_f16", base_addr, 513);
      if (f == 31) chk("anim_f31", base_addr, 513);
      if (f == 32) chk("anim_f32", base_addr, 0);
      if (f == 48) chk("anim_f48", base_addr, 1026);
      if (f == 64) chk("anim_f64", base_addr, 0);
    end
    chk("walk_sprx", sprx, 356);
    chk("walk_face", face, 0);
    do_frame(6'h02);
    do_frame(6'd0);
    chk("release_base", base_addr, 0);
    chk("release_sprx", sprx, 360);
    do_frame(6'h01);
    chk("left_sprx", sprx, 356);
    chk("left_face", face, 1);
    do_frame(6'h03);
    chk("both_sprx", sprx, 360);
    chk("both_face", face, 0);

    spawn_x = 16'sd799; spawn_y = 16'sd446;
    do_reset();
    do_frame(6'h02);
    chk("wrap_right", sprx, -38);
    spawn_x = -16'sd37;
    do_reset();
    do_frame(6'h01);
    chk("wrap_left", sprx, 800);
    chk("wrap_left_face", face, 1);

    do_frame(6'h10);
    do_frame(6'd0); do_frame(6'd0); do_frame(6'd0);
    chk("midjump_state", state_y, 1);
    chk("midjump_spry", spry, 389);
    spawn_x = 16'sd50; spawn_y = 16'sd300;
    do_reset();
    chk("midrst_sprx", sprx, 50);
    chk("midrst_spry", spry, 300);
    chk("midrst_state", state_y, 2);
    chk("midrst_face", face, 0);

    c_spawn_x = 16'sd760;
    do_creset();
    do_frame(6'h02);
    chk("clamp_right", c_sprx, 762);
    do_frame(6'h02);
    chk("clamp_hold", c_sprx, 762);
    c_spawn_x = 16'sd2;
    do_creset();
    do_frame(6'h01);
    chk("clamp_left", c_sprx, 0);
    chk("clamp_left_face", c_face, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
